duty_window_sampler: RTL and testbench
======================================

# duty_window_sampler

Upstream measurement stage of the duty-cycle display path. Synchronises the raw `Signal` input, samples it at a prescaled rate, and counts high and low samples over a fixed window of `WINDOW` samples. At the end of each window it latches `HighCount`, `LowCount` and `TotalCount` and pulses `Valid`. The latched counts feed the duty-cycle calculation and BCD/seven-segment stages.

## Interface
- `CLOCK_SCALE`, default 2500: `InputClock` cycles per sample tick; legal range 1..2^32-1.
- `WINDOW`, default 200: samples per measurement window; legal range 2..255.
- `InputClock`  in  1  system clock; all logic runs on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Enable`  in  1  synchronous level; 1 = measure, 0 = idle.
- `Signal`  in  1  asynchronous raw input under measurement.
- `HighCount`  out  8  high samples in the last completed window.
- `LowCount`  out  8  low samples in the last completed window.
- `TotalCount`  out  8  `HighCount + LowCount`; always equals `WINDOW` after the first window.
- `Valid`  out  1  one-cycle pulse when the three count outputs update.
- `Busy`  out  1  1 while the state is ARM or MEASURE.

## Operation
- Synchroniser: two flops on `Signal`, giving `SigSync`.
- Tick generator:
  - 32-bit counter that emits a one-cycle `Tick` when it reaches `CLOCK_SCALE - 1`, then wraps to 0.
  - Free-running while `Enable` = 1; held at 0 in IDLE.
  - `CLOCK_SCALE` = 1 gives `Tick` every cycle.
- State machine:
  - **IDLE**: accumulators and sample counter are 0. `Enable` = 1 moves to ARM.
  - **ARM**: waits for the first `Tick`. That tick is consumed for alignment and not counted. Moves to MEASURE.
  - **MEASURE**: on each `Tick`:
    - `HighAcc` += 1 if the sample is 1, else `LowAcc` += 1.
    - `SampleCnt` += 1.
    - When `SampleCnt` reaches `WINDOW`, move to LATCH.
  - **LATCH**: one cycle.
    - Copy the accumulators to the outputs and compute `TotalCount` as an 8-bit sum.
    - Assert `Valid`.
    - Clear the accumulators and `SampleCnt`.
    - Return to MEASURE, or to IDLE if `Enable` = 0.
- `Enable` falling in ARM or MEASURE:
  - Next state is IDLE and the partial window is discarded.
  - Outputs keep their last latched values and `Valid` is not pulsed.
- Arithmetic: no overflow is possible, because `HighAcc + LowAcc` ≤ `WINDOW` ≤ 255.
- Reset values: `HighCount` = `LowCount` = `TotalCount` = 0, `Valid` = 0, `Busy` = 0, state IDLE. The tick counter, synchroniser and filter history are also cleared.

## Timing
- `Signal` to `SigSync`: 2 cycles.
- Window duration: `WINDOW` × `CLOCK_SCALE` cycles after the ARM alignment tick.
- `Valid` rises in the cycle after the `Tick` that completes the window; the outputs change in that same cycle.
- `Valid` period in steady state: exactly `WINDOW` × `CLOCK_SCALE` cycles.
- `Enable` rising to first `Valid`: at most (`WINDOW` + 1) × `CLOCK_SCALE` + 2 cycles.
- If `Tick` coincides with `Enable` falling, IDLE wins and the sample is dropped.
- `Reset` asserted mid-window takes effect immediately and asynchronously. The first window after reset release re-arms.

## Configuration
- `DUTY_GLITCH_FILTER_EN` defined:
  - The sample counted on each `Tick` is the majority of the last three tick-sampled `SigSync` values.
  - The 3-bit history shifts on every `Tick`, including the ARM tick, and is cleared in IDLE.
  - An isolated one-sample pulse is rejected; filtered output lags the input by one tick.
- Macro undefined: the sample is `SigSync` at the `Tick` cycle, with no history register.

## Structure
- `duty_pkg` holds:
  - the state enum `duty_state_t` (IDLE, ARM, MEASURE, LATCH);
  - `COUNT_W` = 8;
  - `SCALE_W` = 32.
- One sub-module, `sample_tick_gen`: the `CLOCK_SCALE` prescaler with an enable input and a `Tick` output. It is reusable by other sampled stages.
- The synchroniser, optional filter, FSM and accumulators are in the top-level module.

## Test plan
All scenarios use `CLOCK_SCALE` = 4 and `WINDOW` = 10.
- **Reset:** apply `Reset` = 1 mid-window → all outputs 0 immediately. After release with `Enable` = 1, the next `Valid` arrives after ARM plus 40 cycles.
- **Constant high:** `Signal` held 1, `Enable` = 1 → `Valid` every 40 cycles with `HighCount` = 10, `LowCount` = 0, `TotalCount` = 10.
- **30 % duty:** `Signal` high for 12 of every 40 cycles, aligned to the ticks → `HighCount` = 3, `LowCount` = 7, `TotalCount` = 10 each window.
- **Enable drop:** drop `Enable` after 6 samples → no `Valid`, outputs hold their previous values, `Busy` = 0 one cycle later. Re-enabling needs a full window plus the ARM tick before the next `Valid`.
- **Glitch:** with `Signal` = 0 and a single 1-cycle high pulse coincident with one `Tick` → `HighCount` = 1 without the filter macro; `HighCount` = 0 with `DUTY_GLITCH_FILTER_EN` defined.
- **Boundary:** `CLOCK_SCALE` = 1, `WINDOW` = 255, `Signal` toggling every cycle → `TotalCount` = 255, and `HighCount` and `LowCount` differ by at most 1.

Source files
------------

// File: rtl/duty_pkg.sv
// Shared types and widths for the duty-cycle measurement path.
package duty_pkg;

  localparam int COUNT_W = 8;
  localparam int SCALE_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LATCH   = 2'd3
  } duty_state_t;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Prescaler emitting a one-cycle Tick every CLOCK_SCALE cycles while enabled.
// Held at zero while disabled so the first Tick is always CLOCK_SCALE cycles after enabling.
module sample_tick_gen
  import duty_pkg::*;
#(
  parameter int unsigned CLOCK_SCALE = 2500
) (
  input  logic InputClock,
  input  logic Reset,
  input  logic Enable,
  output logic Tick
);

  localparam logic [SCALE_W-1:0] LAST = SCALE_W'(CLOCK_SCALE - 32'd1);

  logic [SCALE_W-1:0] count;

  assign Tick = Enable && (count == LAST);

  always_ff @(posedge InputClock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (!Enable || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/duty_window_sampler.sv
// Synchronises Signal, samples it on prescaled ticks and reports high/low counts per WINDOW samples.
// Optional majority-of-three glitch filter on the samples: define DUTY_GLITCH_FILTER_EN.
module duty_window_sampler
  import duty_pkg::*;
#(
  parameter int unsigned CLOCK_SCALE = 2500,
  parameter int unsigned WINDOW      = 200
) (
  input  logic               InputClock,
  input  logic               Reset,
  input  logic               Enable,
  input  logic               Signal,
  output logic [COUNT_W-1:0] HighCount,
  output logic [COUNT_W-1:0] LowCount,
  output logic [COUNT_W-1:0] TotalCount,
  output logic               Valid,
  output logic               Busy
);

  localparam logic [COUNT_W-1:0] WINDOW_LAST = COUNT_W'(WINDOW - 32'd1);

  duty_state_t        state;
  logic [1:0]         sync;
  logic               sig_sync;
  logic               tick_en;
  logic               tick;
  logic               sample;
  logic [COUNT_W-1:0] high_acc;
  logic [COUNT_W-1:0] low_acc;
  logic [COUNT_W-1:0] sample_cnt;
  logic [COUNT_W-1:0] high_next;
  logic [COUNT_W-1:0] low_next;

  assign sig_sync = sync[1];
  assign tick_en  = Enable && (state != IDLE);

  always_ff @(posedge InputClock or posedge Reset) begin
    if (Reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], Signal};
    end
  end

  sample_tick_gen #(
    .CLOCK_SCALE(CLOCK_SCALE)
  ) u_tick_gen (
    .InputClock(InputClock),
    .Reset     (Reset),
    .Enable    (tick_en),
    .Tick      (tick)
  );

`ifdef DUTY_GLITCH_FILTER_EN
  logic [2:0] history;
  logic [2:0] history_next;

  assign history_next = {history[1:0], sig_sync};
  assign sample       = majority3(history_next);

  always_ff @(posedge InputClock or posedge Reset) begin
    if (Reset) begin
      history <= '0;
    end else if (state == IDLE) begin
      history <= '0;
    end else if (tick) begin
      history <= history_next;
    end
  end
`else
  assign sample = sig_sync;
`endif

  assign high_next = high_acc + COUNT_W'(sample);
  assign low_next  = low_acc + COUNT_W'(!sample);

  // A tick landing in LATCH (only possible when CLOCK_SCALE is 1) starts the next window,
  // keeping the Valid period at exactly WINDOW ticks.
  always_ff @(posedge InputClock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      high_acc   <= '0;
      low_acc    <= '0;
      sample_cnt <= '0;
      HighCount  <= '0;
      LowCount   <= '0;
      TotalCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          high_acc   <= '0;
          low_acc    <= '0;
          sample_cnt <= '0;
          if (Enable) state <= ARM;
        end
        ARM: begin
          if (!Enable) state <= IDLE;
          else if (tick) state <= MEASURE;
        end
        MEASURE: begin
          if (!Enable) begin
            state <= IDLE;
          end else if (tick) begin
            if (sample_cnt == WINDOW_LAST) begin
              HighCount  <= high_next;
              LowCount   <= low_next;
              TotalCount <= high_next + low_next;
              state      <= LATCH;
            end else begin
              high_acc   <= high_next;
              low_acc    <= low_next;
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        LATCH: begin
          high_acc   <= COUNT_W'(tick && sample);
          low_acc    <= COUNT_W'(tick && !sample);
          sample_cnt <= COUNT_W'(tick);
          state      <= Enable ? MEASURE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Valid = (state == LATCH);
  assign Busy  = (state == ARM) || (state == MEASURE);

endmodule

// File: tb/tb_duty_window_sampler.sv
// Directed bench for duty_window_sampler: CLOCK_SCALE=4/WINDOW=10 instance plus a 1/255 boundary instance.
module tb_duty_window_sampler;

`ifdef DUTY_GLITCH_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, sig_a, en_b, sig_b;
  logic [7:0] hc_a, lc_a, tc_a, hc_b, lc_b, tc_b;
  logic       vld_a, busy_a, vld_b, busy_b;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  duty_window_sampler #(.CLOCK_SCALE(4), .WINDOW(10)) dut_a (
    .InputClock(clk), .Reset(rst), .Enable(en_a), .Signal(sig_a),
    .HighCount(hc_a), .LowCount(lc_a), .TotalCount(tc_a), .Valid(vld_a), .Busy(busy_a)
  );

  duty_window_sampler #(.CLOCK_SCALE(1), .WINDOW(255)) dut_b (
    .InputClock(clk), .Reset(rst), .Enable(en_b), .Signal(sig_b),
    .HighCount(hc_b), .LowCount(lc_b), .TotalCount(tc_b), .Valid(vld_b), .Busy(busy_b)
  );

  // Inputs change on the falling edge; outputs are read on the following falling edge.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en_a = 1'b0; sig_a = 1'b0; en_b = 1'b0; sig_b = 1'b0;
    repeat (3) @(negedge clk);
    total += 5;
    if (hc_a !== 8'd0) begin bad++; $display("[TB] FAIL reset_high got=%0d want=0", hc_a); end
    if (lc_a !== 8'd0) begin bad++; $display("[TB] FAIL reset_low got=%0d want=0", lc_a); end
    if (tc_a !== 8'd0) begin bad++; $display("[TB] FAIL reset_total got=%0d want=0", tc_a); end
    if (vld_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", vld_a); end
    if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy_a); end
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_constant_high();
    logic exp_v;
    sig_a = 1'b1; en_a = 1'b1;
    for (int n = 0; n <= 124; n++) begin
      next_cycle();
      exp_v = (n >= 44) && (((n - 4) % 40) == 0);
      total += 2;
      if (vld_a !== exp_v) begin bad++; $display("[TB] FAIL high_valid n=%0d got=%b want=%b", n, vld_a, exp_v); end
      if (busy_a !== !exp_v) begin bad++; $display("[TB] FAIL high_busy n=%0d got=%b want=%b", n, busy_a, !exp_v); end
      if (exp_v) begin
        total += 3;
        if (hc_a !== 8'd10) begin bad++; $display("[TB] FAIL high_hc n=%0d got=%0d want=10", n, hc_a); end
        if (lc_a !== 8'd0) begin bad++; $display("[TB] FAIL high_lc n=%0d got=%0d want=0", n, lc_a); end
        if (tc_a !== 8'd10) begin bad++; $display("[TB] FAIL high_tc n=%0d got=%0d want=10", n, tc_a); end
      end
    end
    en_a = 1'b0;
    next_cycle();
    total += 1;
    if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL high_idle_busy got=%b want=0", busy_a); end
  endtask

  task automatic test_duty30();
    logic exp_v;
    en_a = 1'b1;
    for (int n = 0; n <= 84; n++) begin
      sig_a = (n >= 4) && (((n - 4) % 40) < 12);
      next_cycle();
      exp_v = (n >= 44) && (((n - 4) % 40) == 0);
      total += 1;
      if (vld_a !== exp_v) begin bad++; $display("[TB] FAIL duty_valid n=%0d got=%b want=%b", n, vld_a, exp_v); end
      if (exp_v) begin
        total += 3;
        if (hc_a !== 8'd3) begin bad++; $display("[TB] FAIL duty_hc n=%0d got=%0d want=3", n, hc_a); end
        if (lc_a !== 8'd7) begin bad++; $display("[TB] FAIL duty_lc n=%0d got=%0d want=7", n, lc_a); end
        if (tc_a !== 8'd10) begin bad++; $display("[TB] FAIL duty_tc n=%0d got=%0d want=10", n, tc_a); end
      end
    end
    en_a = 1'b0; sig_a = 1'b0;
    next_cycle();
  endtask

  task automatic test_enable_drop();
    en_a = 1'b1; sig_a = 1'b1;
    for (int n = 0; n <= 29; n++) begin
      next_cycle();
      total += 2;
      if (vld_a !== 1'b0) begin bad++; $display("[TB] FAIL drop_valid n=%0d got=%b want=0", n, vld_a); end
      if (busy_a !== 1'b1) begin bad++; $display("[TB] FAIL drop_busy n=%0d got=%b want=1", n, busy_a); end
    end
    en_a = 1'b0;
    next_cycle();
    total += 5;
    if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL drop_busy_off got=%b want=0", busy_a); end
    if (vld_a !== 1'b0) begin bad++; $display("[TB] FAIL drop_no_valid got=%b want=0", vld_a); end
    if (hc_a !== 8'd3) begin bad++; $display("[TB] FAIL drop_hold_hc got=%0d want=3", hc_a); end
    if (lc_a !== 8'd7) begin bad++; $display("[TB] FAIL drop_hold_lc got=%0d want=7", lc_a); end
    if (tc_a !== 8'd10) begin bad++; $display("[TB] FAIL drop_hold_tc got=%0d want=10", tc_a); end
    en_a = 1'b1;
    for (int m = 0; m <= 44; m++) begin
      next_cycle();
      total += 1;
      if (vld_a !== (m == 44)) begin bad++; $display("[TB] FAIL rearm_valid m=%0d got=%b want=%b", m, vld_a, (m == 44)); end
      if (m == 43) begin
        total += 1;
        if (hc_a !== 8'd3) begin bad++; $display("[TB] FAIL rearm_hold_hc got=%0d want=3", hc_a); end
      end
      if (m == 44) begin
        total += 3;
        if (hc_a !== 8'd10) begin bad++; $display("[TB] FAIL rearm_hc got=%0d want=10", hc_a); end
        if (lc_a !== 8'd0) begin bad++; $display("[TB] FAIL rearm_lc got=%0d want=0", lc_a); end
        if (tc_a !== 8'd10) begin bad++; $display("[TB] FAIL rearm_tc got=%0d want=10", tc_a); end
      end
    end
    en_a = 1'b0; sig_a = 1'b0;
    next_cycle();
  endtask

  task automatic test_glitch();
    logic [7:0] exp_hc;
    exp_hc = FILTER ? 8'd0 : 8'd1;
    en_a = 1'b1;
    for (int n = 0; n <= 44; n++) begin
      sig_a = (n == 10);
      next_cycle();
      total += 1;
      if (vld_a !== (n == 44)) begin bad++; $display("[TB] FAIL glitch_valid n=%0d got=%b want=%b", n, vld_a, (n == 44)); end
    end
    total += 3;
    if (hc_a !== exp_hc) begin bad++; $display("[TB] FAIL glitch_hc got=%0d want=%0d", hc_a, exp_hc); end
    if (lc_a !== 8'd10 - exp_hc) begin bad++; $display("[TB] FAIL glitch_lc got=%0d want=%0d", lc_a, 8'd10 - exp_hc); end
    if (tc_a !== 8'd10) begin bad++; $display("[TB] FAIL glitch_tc got=%0d want=10", tc_a); end
  endtask

  task automatic test_reset_mid();
    repeat (20) next_cycle();
    #2 rst = 1'b1;
    #1;
    total += 5;
    if (hc_a !== 8'd0) begin bad++; $display("[TB] FAIL midrst_hc got=%0d want=0", hc_a); end
    if (lc_a !== 8'd0) begin bad++; $display("[TB] FAIL midrst_lc got=%0d want=0", lc_a); end
    if (tc_a !== 8'd0) begin bad++; $display("[TB] FAIL midrst_tc got=%0d want=0", tc_a); end
    if (vld_a !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got=%b want=0", vld_a); end
    if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", busy_a); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n <= 44; n++) begin
      next_cycle();
      total += 1;
      if (vld_a !== (n == 44)) begin bad++; $display("[TB] FAIL postrst_valid n=%0d got=%b want=%b", n, vld_a, (n == 44)); end
    end
    total += 3;
    if (hc_a !== 8'd0) begin bad++; $display("[TB] FAIL postrst_hc got=%0d want=0", hc_a); end
    if (lc_a !== 8'd10) begin bad++; $display("[TB] FAIL postrst_lc got=%0d want=10", lc_a); end
    if (tc_a !== 8'd10) begin bad++; $display("[TB] FAIL postrst_tc got=%0d want=10", tc_a); end
    en_a = 1'b0;
    next_cycle();
  endtask

  task automatic test_boundary();
    int first = -1;
    int second = -1;
    int diff;
    en_b = 1'b1;
    for (int i = 0; i < 700 && second < 0; i++) begin
      sig_b = ~sig_b;
      next_cycle();
      if (vld_b === 1'b1) begin
        if (first < 0) first = i;
        else second = i;
        diff = int'(hc_b) - int'(lc_b);
        total += 3;
        if (tc_b !== 8'd255) begin bad++; $display("[TB] FAIL bound_tc i=%0d got=%0d want=255", i, tc_b); end
        if (int'(hc_b) + int'(lc_b) != 255) begin bad++; $display("[TB] FAIL bound_sum i=%0d got=%0d want=255", i, int'(hc_b) + int'(lc_b)); end
        if (diff > 1 || diff < -1) begin bad++; $display("[TB] FAIL bound_balance i=%0d got=%0d/%0d want diff<=1", i, hc_b, lc_b); end
      end
    end
    total += 2;
    if (first < 0 || first > 258) begin bad++; $display("[TB] FAIL bound_first got=%0d want<=258", first); end
    if (second - first != 255) begin bad++; $display("[TB] FAIL bound_period got=%0d want=255", second - first); end
    en_b = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_constant_high();
    test_duty30();
    test_enable_drop();
    test_glitch();
    test_reset_mid();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
